// File: rtl/decode_stage.sv
// decode_stage: ID stage of the IF/ID/EX/WB pipeline.
// Decodes the fetched instruction, drives the register file read addresses,
// bypasses pending EX/WB results into the operands, stalls on RAW hazards and
// registers the decoded bundle into the ID/EX register under valid/ready.
// Optional feature macro: DEC_FWD_EX_EN (EX->ID bypass of ex_result; with it
// only load-use hazards stall, without it any EX destination match stalls).
module decode_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [PC_W-1:0]    if_pc,
  output logic               id_ready,
  output logic [ADDR_W-1:0]  rs_add1,
  output logic [ADDR_W-1:0]  rs_add2,
  input  logic [DATA_W-1:0]  read1,
  input  logic [DATA_W-1:0]  read2,
  input  logic               ex_enw,
  input  logic               ex_is_load,
  input  logic [ADDR_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               wb_enw,
  input  logic [ADDR_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         out_opcode,
  output logic [ADDR_W-1:0]  out_rd,
  output logic [DATA_W-1:0]  out_op1,
  output logic [DATA_W-1:0]  out_op2,
  output logic [15:0]        out_imm,
  output logic [PC_W-1:0]    out_pc
);

`ifdef DEC_FWD_EX_EN
  localparam bit FWD_EX = 1'b1;
`else
  localparam bit FWD_EX = 1'b0;
`endif

  // Operand selection: r0 reads as zero, then EX (non-load, when enabled),
  // then WB (the regfile writes at the same edge we sample), then the regfile.
  function automatic logic signed [DATA_W-1:0] bypass(
    input logic [ADDR_W-1:0]        src,
    input logic signed [DATA_W-1:0] rdata,
    input logic                     ex_en,
    input logic                     ex_load,
    input logic [ADDR_W-1:0]        ex_dst,
    input logic signed [DATA_W-1:0] ex_val,
    input logic                     wb_en,
    input logic [ADDR_W-1:0]        wb_dst,
    input logic signed [DATA_W-1:0] wb_val
  );
    logic signed [DATA_W-1:0] res;
    if (src == '0)
      res = '0;
    else if (FWD_EX && ex_en && !ex_load && (ex_dst == src))
      res = ex_val;
    else if (wb_en && (wb_dst == src))
      res = wb_val;
    else
      res = rdata;
    return res;
  endfunction

  // ---- ID stage (p0): decode, bypass, hazard detection ----
  logic [5:0]               opcode_p0;
  logic [ADDR_W-1:0]        rd_p0;
  logic [ADDR_W-1:0]        rs1_p0;
  logic [ADDR_W-1:0]        rs2_p0;
  logic [15:0]              imm_p0;
  logic signed [DATA_W-1:0] op1_p0;
  logic signed [DATA_W-1:0] op2_p0;
  logic                     src_match;
  logic                     hazard;
  logic                     can_load;
  logic                     load_en;

  assign opcode_p0 = if_instr[31:26];
  assign rd_p0     = if_instr[25:21];
  assign rs1_p0    = if_instr[20:16];
  assign rs2_p0    = if_instr[15:11];
  assign imm_p0    = if_instr[15:0];

  assign rs_add1 = rs1_p0;
  assign rs_add2 = rs2_p0;

  assign op1_p0 = bypass(rs1_p0, read1, ex_enw, ex_is_load, ex_rd, ex_result,
                         wb_enw, wb_rd, wb_data);
  assign op2_p0 = bypass(rs2_p0, read2, ex_enw, ex_is_load, ex_rd, ex_result,
                         wb_enw, wb_rd, wb_data);

  // Both fields are treated as sources for every opcode; r0 never matches.
  assign src_match = (ex_rd != '0) && ((ex_rd == rs1_p0) || (ex_rd == rs2_p0));
  assign hazard    = if_valid && ex_enw && src_match && (ex_is_load || !FWD_EX);

  logic vld_p1;
  assign can_load = !vld_p1 || out_ready;
  assign id_ready = can_load && !hazard && !flush;
  assign load_en  = can_load && if_valid && !hazard;

  // ---- ID/EX register (p1) ----
  logic [5:0]               opcode_p1;
  logic [ADDR_W-1:0]        rd_p1;
  logic signed [DATA_W-1:0] op1_p1;
  logic signed [DATA_W-1:0] op2_p1;
  logic [15:0]              imm_p1;
  logic [PC_W-1:0]          pc_p1;

  // ID/EX register update: flush kills, otherwise load/bubble when EX can take it, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      opcode_p1 <= '0;
      rd_p1     <= '0;
      op1_p1    <= '0;
      op2_p1    <= '0;
      imm_p1    <= '0;
      pc_p1     <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (can_load) begin
      vld_p1 <= load_en;
      if (load_en) begin
        opcode_p1 <= opcode_p0;
        rd_p1     <= rd_p0;
        op1_p1    <= op1_p0;
        op2_p1    <= op2_p0;
        imm_p1    <= imm_p0;
        pc_p1     <= if_pc;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_opcode = opcode_p1;
  assign out_rd     = rd_p1;
  assign out_op1    = op1_p1;
  assign out_op2    = op2_p1;
  assign out_imm    = imm_p1;
  assign out_pc     = pc_p1;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// A scoreboard predicts every accepted bundle when stimulus is applied and
// compares it when EX consumes the ID/EX register; scenario tasks add
// directed inline checks. Honors DEC_FWD_EX_EN the same way as the design.
module tb_decode_stage;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 16;

`ifdef DEC_FWD_EX_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               id_ready;
  logic [ADDR_W-1:0]  rs_add1;
  logic [ADDR_W-1:0]  rs_add2;
  logic [DATA_W-1:0]  read1;
  logic [DATA_W-1:0]  read2;
  logic               ex_enw;
  logic               ex_is_load;
  logic [ADDR_W-1:0]  ex_rd;
  logic [DATA_W-1:0]  ex_result;
  logic               wb_enw;
  logic [ADDR_W-1:0]  wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [5:0]         out_opcode;
  logic [ADDR_W-1:0]  out_rd;
  logic [DATA_W-1:0]  out_op1;
  logic [DATA_W-1:0]  out_op2;
  logic [15:0]        out_imm;
  logic [PC_W-1:0]    out_pc;

  decode_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PC_W(PC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rs_add1(rs_add1), .rs_add2(rs_add2),
    .read1(read1), .read2(read2),
    .ex_enw(ex_enw), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .wb_enw(wb_enw), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_op1(out_op1),
    .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc)
  );

  typedef struct {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] imm;
    logic [15:0] pc;
  } bundle_t;

  bundle_t sb[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [10:0] lo);
    return {op, rd, s1, s2, lo};
  endfunction

  // Reference operand value: start from the regfile and let later sources override.
  function automatic logic [15:0] m_opnd(input logic [4:0] a, input logic [15:0] rf);
    logic [15:0] v;
    v = rf;
    if (wb_enw && wb_rd == a) v = wb_data;
    if (FWD && ex_enw && !ex_is_load && ex_rd == a) v = ex_result;
    if (a == 5'd0) v = 16'h0000;
    return v;
  endfunction

  // Scoreboard: mid-cycle, predict the coming edge and compare what EX consumes.
  always @(negedge clk) begin
    bundle_t eb;
    logic [4:0] s1, s2;
    logic mvalid, mcan, mhaz, mready;
    if (rst) begin
      sb.delete();
    end else begin
      s1     = if_instr[20:16];
      s2     = if_instr[15:11];
      mvalid = (sb.size() != 0);
      mcan   = !mvalid || out_ready;
      mhaz   = if_valid && ex_enw && (ex_rd != 5'd0) && (ex_rd == s1 || ex_rd == s2)
               && (ex_is_load || !FWD);
      mready = mcan && !mhaz && !flush;
      checks++;
      if (out_valid !== mvalid) begin
        errors++;
        $display("FAIL sb_out_valid t=%0t got %b want %b", $time, out_valid, mvalid);
      end
      checks++;
      if (id_ready !== mready) begin
        errors++;
        $display("FAIL sb_id_ready t=%0t got %b want %b", $time, id_ready, mready);
      end
      if (mvalid && out_ready && !flush) begin
        eb = sb[0];
        checks++;
        if ({out_opcode, out_rd, out_op1, out_op2, out_imm, out_pc} !==
            {eb.opcode, eb.rd, eb.op1, eb.op2, eb.imm, eb.pc}) begin
          errors++;
          $display("FAIL sb_bundle t=%0t got op=%h rd=%h a=%h b=%h imm=%h pc=%h want op=%h rd=%h a=%h b=%h imm=%h pc=%h",
                   $time, out_opcode, out_rd, out_op1, out_op2, out_imm, out_pc,
                   eb.opcode, eb.rd, eb.op1, eb.op2, eb.imm, eb.pc);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (mcan) begin
        if (mvalid) void'(sb.pop_front());
        if (if_valid && !mhaz) begin
          eb.opcode = if_instr[31:26];
          eb.rd     = if_instr[25:21];
          eb.op1    = m_opnd(s1, read1);
          eb.op2    = m_opnd(s2, read2);
          eb.imm    = if_instr[15:0];
          eb.pc     = if_pc;
          sb.push_back(eb);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid   = 1'b0;
    ex_enw     = 1'b0;
    ex_is_load = 1'b0;
    wb_enw     = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm, out_pc} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b op=%h a=%h b=%h want all zero", out_valid, out_opcode, out_op1, out_op2);
    end
    step();
    rst = 1'b0;
    if_valid = 1'b1;
    if_instr = mk(6'h0A, 5'd7, 5'd1, 5'd2, 11'h155);
    if_pc    = 16'h0100;
    read1    = 16'h1111;
    read2    = 16'h2222;
    step();
    if_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_valid got %b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm, out_pc} !== '0) begin
      errors++;
      $display("FAIL reset_async got v=%b op=%h rd=%h a=%h b=%h imm=%h pc=%h want all zero",
               out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm, out_pc);
    end
    step();
    rst = 1'b0;
    idle();
    step();
  endtask

  task automatic test_wb_bypass();
    idle();
    wb_enw = 1'b1; wb_rd = 5'd3; wb_data = 16'h1234;
    read1 = 16'h0000; read2 = 16'h0BBB;
    if_valid = 1'b1;
    if_instr = mk(6'h01, 5'd2, 5'd3, 5'd6, 11'h011);
    if_pc = 16'h0200;
    #1;
    checks++;
    if (rs_add1 !== 5'd3 || rs_add2 !== 5'd6) begin
      errors++;
      $display("FAIL rs_addr got %0d/%0d want 3/6", rs_add1, rs_add2);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 16'h1234) begin
      errors++;
      $display("FAIL wb_bypass got v=%b op1=%h want 1 1234", out_valid, out_op1);
    end
    wb_rd = 5'd0; wb_data = 16'hFFFF; read1 = 16'h5555;
    if_instr = mk(6'h02, 5'd4, 5'd0, 5'd6, 11'h022);
    step();
    checks++;
    if (out_op1 !== 16'h0000) begin
      errors++;
      $display("FAIL r0_zero got %h want 0000", out_op1);
    end
    idle();
    step();
  endtask

  task automatic test_load_use();
    idle();
    ex_enw = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4; ex_result = 16'hDEAD;
    read1 = 16'h0101; read2 = 16'h7777;
    if_valid = 1'b1;
    if_instr = mk(6'h03, 5'd8, 5'd1, 5'd4, 11'h033);
    if_pc = 16'h0300;
    #1;
    checks++;
    if (id_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_use_stall got id_ready=%b want 0", id_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble got out_valid=%b want 0", out_valid);
    end
    ex_enw = 1'b0; ex_is_load = 1'b0;
    wb_enw = 1'b1; wb_rd = 5'd4; wb_data = 16'h00AB; read2 = 16'h0000;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_use_release got id_ready=%b want 1", id_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_op2 !== 16'h00AB) begin
      errors++;
      $display("FAIL load_use_fwd got v=%b op2=%h want 1 00ab", out_valid, out_op2);
    end
    idle();
    step();
  endtask

  task automatic test_alu_dep();
    idle();
    ex_enw = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd5; ex_result = 16'h0042;
    read1 = 16'h9999; read2 = 16'h0000;
    if_valid = 1'b1;
    if_instr = mk(6'h04, 5'd9, 5'd5, 5'd0, 11'h044);
    if_pc = 16'h0400;
    #1;
    checks++;
    if (id_ready !== FWD) begin
      errors++;
      $display("FAIL alu_dep_ready got %b want %b", id_ready, FWD);
    end
    step();
    if (!FWD) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL alu_dep_bubble got out_valid=%b want 0", out_valid);
      end
      ex_enw = 1'b0;
      wb_enw = 1'b1; wb_rd = 5'd5; wb_data = 16'h0042;
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 16'h0042) begin
      errors++;
      $display("FAIL alu_dep_op1 got v=%b op1=%h want 1 0042", out_valid, out_op1);
    end
    idle();
    step();
  endtask

  task automatic test_backpressure();
    idle();
    read1 = 16'h0A0A; read2 = 16'h0B0B;
    if_valid = 1'b1;
    if_instr = mk(6'h11, 5'd9, 5'd7, 5'd8, 11'h2AA);
    if_pc = 16'h0500;
    step();
    out_ready = 1'b0;
    if_instr = mk(6'h12, 5'd10, 5'd1, 5'd2, 11'h0F0);
    if_pc = 16'h0504;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready cyc=%0d got %b want 0", i, id_ready);
      end
      step();
      checks++;
      if ({out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm, out_pc} !==
          {1'b1, 6'h11, 5'd9, 16'h0A0A, 16'h0B0B, {5'd8, 11'h2AA}, 16'h0500}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b op=%h rd=%h a=%h b=%h imm=%h pc=%h want held bundle",
                 i, out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm, out_pc);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_opcode !== 6'h12 || out_pc !== 16'h0504) begin
      errors++;
      $display("FAIL bp_resume got v=%b op=%h pc=%h want 1 12 0504", out_valid, out_opcode, out_pc);
    end
  endtask

  task automatic test_flush_stall();
    out_ready = 1'b0;
    flush = 1'b1;
    if_instr = mk(6'h13, 5'd11, 5'd3, 5'd3, 11'h000);
    #1;
    checks++;
    if (id_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_bp_ready got %b want 0", id_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_bp_valid got %b want 0", out_valid);
    end
    flush = 1'b0; out_ready = 1'b1;
    step();
    ex_enw = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
    flush = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_haz_valid got %b want 0", out_valid);
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      if_valid   = ($urandom_range(0, 3) != 0);
      if_instr   = mk(6'($urandom), 5'($urandom), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 11'($urandom));
      if_pc      = 16'($urandom);
      read1      = 16'($urandom);
      read2      = 16'($urandom);
      ex_enw     = ($urandom_range(0, 1) != 0);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_rd      = 5'($urandom_range(0, 3));
      ex_result  = 16'($urandom);
      wb_enw     = ($urandom_range(0, 1) != 0);
      wb_rd      = 5'($urandom_range(0, 3));
      wb_data    = 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    if_instr = '0; if_pc = '0; read1 = '0; read2 = '0;
    ex_rd = '0; ex_result = '0; wb_rd = '0; wb_data = '0;
    test_reset();
    test_wb_bypass();
    test_load_use();
    test_alu_dep();
    test_backpressure();
    test_flush_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
